ib32bit_next_pc: RTL and testbench

IB32BIT_NEXT_PC -- requirements
Module: ib32bit_next_pc

---
 rtl/ib32bit_pkg.sv | 26 ++
 rtl/ib32bit_ras.sv | 66 ++++++
 rtl/ib32bit_next_pc.sv | 166 ++++++++++++++++
 tb/tb_ib32bit_next_pc.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ib32bit_pkg.sv
// Shared definitions for the next-PC generator.
//   AWIDTH_DEFAULT    default instruction address width
//   RAS_DEPTH_DEFAULT default return-address-stack depth
//   state_e           sequencer states (IDLE/RUN/REDIRECT/HALT)
//   cause_e           reason for a redirect taken from RUN
package ib32bit_pkg;

   localparam int unsigned AWIDTH_DEFAULT    = 6;
   localparam int unsigned RAS_DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StRedirect,
      StHalt
   } state_e;

   typedef enum logic [2:0] {
      CauseNone,
      CauseRet,
      CauseCall,
      CauseJump,
      CauseBranch
   } cause_e;

endpackage

// File: rtl/ib32bit_ras.sv
// Circular return-address stack.
//   clk, rst_n  clock, asynchronous active-low reset (empties the stack)
//   push, din   store din on top; when full the oldest entry is overwritten
//   pop         discard the top entry (ignored when empty)
//   dout        current top entry
//   empty, full occupancy flags
module ib32bit_ras #(
   parameter int unsigned AWIDTH = 6,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [AWIDTH-1:0] din,
   output logic [AWIDTH-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LastIdx   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [AWIDTH-1:0] mem_q [DEPTH];
   // ptr_q is the next slot to write; the top entry sits just below it.
   logic [PW-1:0]     ptr_q, ptr_d, top_idx;
   logic [CW-1:0]     count_q, count_d;

   assign top_idx = (ptr_q == '0) ? LastIdx : ptr_q - 1'b1;
   assign dout    = mem_q[top_idx];
   assign empty   = (count_q == '0);
   assign full    = (count_q == FullCount);

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      if (push) begin
         ptr_d = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;
         if (!full) begin
            count_d = count_q + 1'b1;
         end
      end else if (pop && !empty) begin
         ptr_d   = top_idx;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[ptr_q] <= din;
      end
   end

endmodule

// File: rtl/ib32bit_next_pc.sv
// Next fetch address sequencer.
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 hold the current address
//   halt                  stop fetching until reset
//   br_taken, br_target   resolved taken branch
//   jump, jump_target     unconditional jump
//   call, ret             subroutine call (to jump_target) / return
//   addr, valid           next fetch address and its qualifier
//   flush                 one-cycle pulse: drop the in-flight instruction
//   wrap                  pulse when addr wraps from all-ones to zero
//   ras_err               pulse on a return with an empty stack
// Build option: define IB32BIT_RAS_EN to add the return-address stack; without it
// call acts as jump, ret is ignored and ras_err stays 0.
module ib32bit_next_pc
   import ib32bit_pkg::*;
#(
   parameter int unsigned AWIDTH    = AWIDTH_DEFAULT,
   parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              halt,
   input  logic              br_taken,
   input  logic [AWIDTH-1:0] br_target,
   input  logic              jump,
   input  logic [AWIDTH-1:0] jump_target,
   input  logic              call,
   input  logic              ret,
   output logic [AWIDTH-1:0] addr,
   output logic              valid,
   output logic              flush,
   output logic              wrap,
   output logic              ras_err
);

   state_e            state_q, state_d;
   cause_e            cause;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic              flush_q, flush_d;
   logic              wrap_q, wrap_d;
   logic              ras_err_q, ras_err_d;
   logic              ret_req;
   logic              ras_empty;
   logic [AWIDTH-1:0] ras_dout;

`ifdef IB32BIT_RAS_EN
   logic              ras_push, ras_pop, ras_full;
   logic [AWIDTH-1:0] ras_din;

   assign ret_req  = ret;
   assign ras_din  = addr_q + 1'b1;
   assign ras_push = (state_q == StRun) && !halt && (cause == CauseCall);
   assign ras_pop  = (state_q == StRun) && !halt && (cause == CauseRet) && !ras_empty;

   ib32bit_ras #(
      .AWIDTH (AWIDTH),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (ras_din),
      .dout  (ras_dout),
      .empty (ras_empty),
      .full  (ras_full)
   );
`else
   // Without a stack a return has nothing to pop, so it never takes effect.
   assign ret_req   = ret & 1'b0;
   assign ras_empty = 1'b1;
   assign ras_dout  = '0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      valid_d   = valid_q;
      flush_d   = 1'b0;
      wrap_d    = 1'b0;
      ras_err_d = 1'b0;
      cause     = CauseNone;

      unique case (state_q)
         StIdle: begin
            state_d = StRun;
            addr_d  = '0;
            valid_d = 1'b1;
         end
         StRun: begin
            if (halt) begin
               state_d = StHalt;
               valid_d = 1'b0;
            end else begin
               if (ret_req)       cause = CauseRet;
               else if (call)     cause = CauseCall;
               else if (jump)     cause = CauseJump;
               else if (br_taken) cause = CauseBranch;

               case (cause)
                  CauseRet: begin
                     addr_d    = ras_empty ? '0 : ras_dout;
                     ras_err_d = ras_empty;
                  end
                  CauseCall, CauseJump: addr_d = jump_target;
                  CauseBranch:          addr_d = br_target;
                  default: begin
                     if (!stall) begin
                        addr_d = addr_q + 1'b1;
                        wrap_d = &addr_q;
                     end
                  end
               endcase

               if (cause != CauseNone) begin
                  state_d = StRedirect;
                  valid_d = 1'b0;
                  flush_d = 1'b1;
               end
            end
         end
         StRedirect: begin
            // New redirect requests are dropped here; only halt and stall matter.
            if (halt) begin
               state_d = StHalt;
            end else if (!stall) begin
               state_d = StRun;
               valid_d = 1'b1;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         flush_q   <= 1'b0;
         wrap_q    <= 1'b0;
         ras_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         flush_q   <= flush_d;
         wrap_q    <= wrap_d;
         ras_err_q <= ras_err_d;
      end
   end

   assign addr    = addr_q;
   assign valid   = valid_q;
   assign flush   = flush_q;
   assign wrap    = wrap_q;
   assign ras_err = ras_err_q;

endmodule

// File: tb/tb_ib32bit_next_pc.sv
module tb_ib32bit_next_pc;

   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 4;
   localparam int          N     = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0, halt = 1'b0, br_taken = 1'b0, jump = 1'b0;
   logic          call = 1'b0, ret = 1'b0;
   logic [AW-1:0] br_target = '0, jump_target = '0;
   logic [AW-1:0] addr;
   logic          valid, flush, wrap, ras_err;

   int checks = 0;
   int errors = 0;
   int wraps_seen = 0;
   bit chk_en = 1'b0;

   // Behavioural expectation: what the outputs must show after each edge.
   int e_addr;
   bit e_valid, e_flush, e_wrap, e_err;
   bit m_started, m_halted, m_bubble;
   int ras[$];

   ib32bit_next_pc #(
      .AWIDTH    (AW),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .halt        (halt),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .call        (call),
      .ret         (ret),
      .addr        (addr),
      .valid       (valid),
      .flush       (flush),
      .wrap        (wrap),
      .ras_err     (ras_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      e_addr = 0; e_valid = 0; e_flush = 0; e_wrap = 0; e_err = 0;
      m_started = 0; m_halted = 0; m_bubble = 0;
      ras.delete();
   endtask

   task automatic model_step();
      bit redir;
      int tgt;
      if (!rst_n) return;
      e_flush = 0; e_wrap = 0; e_err = 0;
      redir = 0; tgt = 0;
      if (!m_started) begin
         m_started = 1; e_addr = 0; e_valid = 1;
      end else if (m_halted) begin
         e_valid = 0;
      end else if (halt) begin
         m_halted = 1; e_valid = 0;
      end else if (m_bubble) begin
         if (!stall) begin
            m_bubble = 0; e_valid = 1;
         end
      end else begin
`ifdef IB32BIT_RAS_EN
         if (ret) begin
            redir = 1;
            if (ras.size() == 0) begin
               tgt = 0; e_err = 1;
            end else begin
               tgt = ras.pop_back();
            end
         end else
`endif
         if (call) begin
`ifdef IB32BIT_RAS_EN
            ras.push_back((e_addr + 1) % N);
            if (ras.size() > int'(DEPTH)) void'(ras.pop_front());
`endif
            redir = 1; tgt = int'(jump_target);
         end else if (jump) begin
            redir = 1; tgt = int'(jump_target);
         end else if (br_taken) begin
            redir = 1; tgt = int'(br_target);
         end
         if (redir) begin
            e_addr = tgt; e_valid = 0; e_flush = 1; m_bubble = 1;
         end else if (!stall) begin
            e_wrap = (e_addr == N - 1);
            e_addr = (e_addr + 1) % N;
         end
      end
   endtask

   // Compare process: every negedge, DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("addr", int'(addr), e_addr);
         check("valid", int'(valid), int'(e_valid));
         check("flush", int'(flush), int'(e_flush));
         check("wrap", int'(wrap), int'(e_wrap));
         check("ras_err", int'(ras_err), int'(e_err));
         if (wrap) wraps_seen++;
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; halt = 0; br_taken = 0; jump = 0; call = 0; ret = 0;
      br_target = '0; jump_target = '0;
   endtask

   // Reset, release, then run until addr == k.
   task automatic restart(input int k);
      rst_n = 0;
      model_reset();
      clear_inputs();
      tick();
      tick();
      rst_n = 1;
      repeat (k + 1) tick();
   endtask

   task automatic expect_out(input string tag, input int a, input int v, input int f);
      check({tag, ".addr"}, int'(addr), a);
      check({tag, ".valid"}, int'(valid), v);
      check({tag, ".flush"}, int'(flush), f);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int exp_ret[5];
      exp_ret[0] = 53; exp_ret[1] = 49; exp_ret[2] = 45; exp_ret[3] = 41; exp_ret[4] = 0;

      model_reset();
      #1;
      chk_en = 1;

      // Reset state and free run across the wrap.
      tick();
      expect_out("reset", 0, 0, 0);
      rst_n = 1;
      tick();
      expect_out("first_edge", 0, 1, 0);
      wraps_seen = 0;
      repeat (69) tick();
      check("free_run.addr", int'(addr), 5);
      check("free_run.wraps", wraps_seen, 1);

      // Stall at 5, then taken branch to 20.
      restart(5);
      check("pre_stall.addr", int'(addr), 5);
      stall = 1;
      repeat (3) begin
         tick();
         expect_out("stall", 5, 1, 0);
      end
      stall = 0; br_taken = 1; br_target = AW'(20);
      tick();
      expect_out("branch", 20, 0, 1);
      br_taken = 0;
      tick();
      expect_out("branch_land", 20, 1, 0);
      tick();
      check("branch_next.addr", int'(addr), 21);

      // Jump wins over branch.
      restart(7);
      jump = 1; jump_target = AW'(40); br_taken = 1; br_target = AW'(12);
      tick();
      expect_out("jump_br", 40, 0, 1);
      jump = 0; br_taken = 0;
      tick();
      expect_out("jump_land", 40, 1, 0);

      // Stall extends the bubble; redirects inside the bubble are dropped.
      jump = 1; jump_target = AW'(50); stall = 1;
      tick();
      expect_out("stall_redir", 50, 0, 1);
      jump = 0;
      tick();
      expect_out("bubble_ext", 50, 0, 0);
      tick();
      expect_out("bubble_ext2", 50, 0, 0);
      stall = 0; jump = 1; jump_target = AW'(3);
      tick();
      expect_out("bubble_ignore", 50, 1, 0);
      jump = 0;
      tick();
      check("after_bubble.addr", int'(addr), 51);

      // Redirect to the current address still bubbles.
      jump = 1; jump_target = AW'(51);
      tick();
      expect_out("self_jump", 51, 0, 1);
      jump = 0;
      tick();
      expect_out("self_land", 51, 1, 0);

      // Call / return.
      restart(9);
      call = 1; jump_target = AW'(30);
      tick();
      expect_out("call", 30, 0, 1);
      call = 0;
      tick();
      tick();
      check("call_run.addr", int'(addr), 31);
      ret = 1;
      tick();
`ifdef IB32BIT_RAS_EN
      expect_out("ret", 10, 0, 1);
      check("ret.ras_err", int'(ras_err), 0);
      ret = 0;
      tick();
      expect_out("ret_land", 10, 1, 0);
      for (int i = 0; i < 5; i++) begin
         call = 1; jump_target = AW'(40 + 4 * i);
         tick();
         call = 0;
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         ret = 1;
         tick();
         expect_out("ret_chain", exp_ret[i], 0, 1);
         check("ret_chain.ras_err", int'(ras_err), (i == 4) ? 1 : 0);
         ret = 0;
         tick();
      end
`else
      expect_out("ret_ignored", 32, 1, 0);
      check("ret_ignored.ras_err", int'(ras_err), 0);
      ret = 0;
      tick();
      check("ret_ignored_next.addr", int'(addr), 33);
`endif

      // Halt holds the address; everything else is ignored.
      restart(15);
      halt = 1;
      tick();
      expect_out("halt", 15, 0, 0);
      halt = 0; jump = 1; jump_target = AW'(40);
      repeat (3) begin
         tick();
         expect_out("halted", 15, 0, 0);
      end

      // Asynchronous reset in the middle of a redirect bubble.
      restart(0);
      expect_out("restart", 0, 1, 0);
      jump = 1; jump_target = AW'(40);
      tick();
      expect_out("pre_abort", 40, 0, 1);
      jump = 0;
      #2;
      rst_n = 0;
      model_reset();
      #1;
      expect_out("async_rst", 0, 0, 0);
      @(negedge clk);
      #1;
      rst_n = 1;
      tick();
      expect_out("post_rst", 0, 1, 0);
      tick();
      check("post_rst_next.addr", int'(addr), 1);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
